// File: rtl/cache_pkg.sv
// Shared geometry, FSM states and line layout for the 4-way set-associative cache.
// Line word w lives at bits [blk_w_offset -: 32]; word 0 sits at the MSB end.
package cache_pkg;

  localparam int no_of_banks      = 4;
  localparam int bank_addr_width  = 8;
  localparam int mem_word_size    = 32;
  localparam int proc_word_size   = 32;
  localparam int bank_word_size   = 32;
  localparam int blk_0_offset     = 127;
  localparam int blk_1_offset     = 95;
  localparam int blk_2_offset     = 63;
  localparam int blk_3_offset     = 31;
  localparam int data_bus_width   = 32;
  localparam int addr_bus_width   = 32;
  localparam int INDEX_BITS       = 2;
  localparam int TAG_BITS         = 6;
  localparam int SET_OFFSET_BITS  = 2;
  localparam int loctn_bits       = INDEX_BITS + SET_OFFSET_BITS;
  localparam int offset_bits      = 2;
  localparam int block_size       = 128;
  localparam int bulk_read_size   = 128;
  localparam int addr_width       = 10;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    REFILL,
    FILL,
    FLUSH
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TAG_BITS-1:0]        tag;
    logic [block_size-1:0]      data;
  } line_t;

  function automatic logic [proc_word_size-1:0] get_word(
    input logic [block_size-1:0]  line,
    input logic [offset_bits-1:0] off
  );
    case (off)
      2'd0:    return line[blk_0_offset -: proc_word_size];
      2'd1:    return line[blk_1_offset -: proc_word_size];
      2'd2:    return line[blk_2_offset -: proc_word_size];
      default: return line[blk_3_offset -: proc_word_size];
    endcase
  endfunction

  function automatic logic [block_size-1:0] put_word(
    input logic [block_size-1:0]     line,
    input logic [offset_bits-1:0]    off,
    input logic [proc_word_size-1:0] word
  );
    logic [block_size-1:0] merged;
    merged = line;
    case (off)
      2'd0:    merged[blk_0_offset -: proc_word_size] = word;
      2'd1:    merged[blk_1_offset -: proc_word_size] = word;
      2'd2:    merged[blk_2_offset -: proc_word_size] = word;
      default: merged[blk_3_offset -: proc_word_size] = word;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/cache_mem_bank.sv
// Single-port 256x32 synchronous RAM; one instance holds one word position of every line.
// Read-before-write on a shared address, registered read data.
module cache_mem_bank
  import cache_pkg::*;
(
  input  logic                       clock,
  input  logic                       we,
  input  logic [bank_addr_width-1:0] addr,
  input  logic [bank_word_size-1:0]  wdata,
  output logic [bank_word_size-1:0]  rdata
);

  logic [mem_word_size-1:0] mem_reg [1 << bank_addr_width];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    rdata <= mem_reg[addr];
  end

endmodule

// File: rtl/set_assoc_cache_top.sv
// 4 sets x 4 ways write-back, write-allocate cache with a word-interleaved 4-bank backing store.
// Lookup happens only in IDLE; misses walk WB -> REFILL -> FILL, flush walks every line in order.
module set_assoc_cache_top
  import cache_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [addr_bus_width-1:0] addr,
  input  logic [data_bus_width-1:0] wdata,
  output logic [data_bus_width-1:0] rdata,
  input  logic                      flush,
  input  logic                      rd,
  input  logic                      wr,
  output logic                      stall
);

  localparam int num_ways  = 1 << SET_OFFSET_BITS;
  localparam int num_lines = 1 << loctn_bits;

  state_t                        state_reg;
  line_t                         lines_reg [num_lines];
  logic [SET_OFFSET_BITS-1:0]    age_reg [num_lines];
  logic [addr_width-1:0]         req_addr_reg;
  logic [proc_word_size-1:0]     req_wdata_reg;
  logic                          req_wr_reg;
  logic [SET_OFFSET_BITS-1:0]    victim_way_reg;
  logic [loctn_bits-1:0]         flush_idx_reg;
  logic                          flush_wr_reg;

  logic [TAG_BITS-1:0]           in_tag, req_tag;
  logic [INDEX_BITS-1:0]         in_index, req_index;
  logic [offset_bits-1:0]        in_off, req_off;
  logic                          unused_addr_bits;

  assign in_tag    = addr[addr_width-1 -: TAG_BITS];
  assign in_index  = addr[offset_bits +: INDEX_BITS];
  assign in_off    = addr[offset_bits-1:0];
  assign req_tag   = req_addr_reg[addr_width-1 -: TAG_BITS];
  assign req_index = req_addr_reg[offset_bits +: INDEX_BITS];
  assign req_off   = req_addr_reg[offset_bits-1:0];
  assign unused_addr_bits = ^addr[addr_bus_width-1:addr_width];

  logic [num_ways-1:0]         hit_vec;
  logic                        hit;
  logic [SET_OFFSET_BITS-1:0]  hit_way;
  logic [SET_OFFSET_BITS-1:0]  victim_way;
  logic                        accept;

  for (genvar gi = 0; gi < num_ways; gi++) begin : g_tag_cmp
    assign hit_vec[gi] = lines_reg[{in_index, SET_OFFSET_BITS'(gi)}].valid &&
                         (lines_reg[{in_index, SET_OFFSET_BITS'(gi)}].tag == in_tag);
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int v = num_ways - 1; v >= 0; v--) begin
      if (hit_vec[v]) begin
        hit     = 1'b1;
        hit_way = SET_OFFSET_BITS'(v);
      end
    end
  end

  // Oldest way has the smallest age; any invalid way (lowest first) overrides it.
  always_comb begin
    logic [SET_OFFSET_BITS-1:0] best_age;
    victim_way = '0;
    best_age   = age_reg[{in_index, SET_OFFSET_BITS'(0)}];
    for (int v = 1; v < num_ways; v++) begin
      if (age_reg[{in_index, SET_OFFSET_BITS'(v)}] < best_age) begin
        best_age   = age_reg[{in_index, SET_OFFSET_BITS'(v)}];
        victim_way = SET_OFFSET_BITS'(v);
      end
    end
    for (int v = num_ways - 1; v >= 0; v--) begin
      if (!lines_reg[{in_index, SET_OFFSET_BITS'(v)}].valid) begin
        victim_way = SET_OFFSET_BITS'(v);
      end
    end
  end

  logic                        touch_en;
  logic [INDEX_BITS-1:0]       touch_index;
  logic [SET_OFFSET_BITS-1:0]  touch_way;
  logic [SET_OFFSET_BITS-1:0]  touched_age [num_ways];

  // The touched way becomes the maximum age; ways younger than it step down by one.
  always_comb begin
    logic [SET_OFFSET_BITS-1:0] ref_age;
    logic [SET_OFFSET_BITS-1:0] cur_age;
    accept      = (state_reg == IDLE) && !flush && (rd || wr);
    touch_en    = (state_reg == FILL) || (accept && hit);
    touch_index = (state_reg == FILL) ? req_index : in_index;
    touch_way   = (state_reg == FILL) ? victim_way_reg : hit_way;
    ref_age     = age_reg[{touch_index, touch_way}];
    for (int v = 0; v < num_ways; v++) begin
      cur_age = age_reg[{touch_index, SET_OFFSET_BITS'(v)}];
      if (SET_OFFSET_BITS'(v) == touch_way) begin
        touched_age[v] = '1;
      end else if (cur_age > ref_age) begin
        touched_age[v] = cur_age - 1'b1;
      end else begin
        touched_age[v] = cur_age;
      end
    end
  end

  logic                        bank_we;
  logic [bank_addr_width-1:0]  bank_addr;
  logic [block_size-1:0]       bank_wline;
  logic [bulk_read_size-1:0]   fill_data;
  line_t                       wb_line;
  logic [INDEX_BITS-1:0]       wb_index;

  always_comb begin
    if (state_reg == FLUSH) begin
      wb_line  = lines_reg[flush_idx_reg];
      wb_index = flush_idx_reg[loctn_bits-1 -: INDEX_BITS];
    end else begin
      wb_line  = lines_reg[{req_index, victim_way_reg}];
      wb_index = req_index;
    end
    bank_we    = (state_reg == WB) || ((state_reg == FLUSH) && flush_wr_reg);
    bank_addr  = bank_we ? {wb_line.tag, wb_index} : req_addr_reg[addr_width-1:offset_bits];
    bank_wline = wb_line.data;
  end

  for (genvar gi = 0; gi < no_of_banks; gi++) begin : g_bank
    cache_mem_bank u_bank (
      .clock (clock),
      .we    (bank_we),
      .addr  (bank_addr),
      .wdata (bank_wline[block_size-1-gi*bank_word_size -: bank_word_size]),
      .rdata (fill_data[bulk_read_size-1-gi*bank_word_size -: bank_word_size])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      stall         <= 1'b0;
      rdata         <= '0;
      flush_idx_reg <= '0;
      flush_wr_reg  <= 1'b0;
      for (int i = 0; i < num_lines; i++) begin
        lines_reg[i].valid <= 1'b0;
        lines_reg[i].dirty <= 1'b0;
        age_reg[i]         <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg     <= FLUSH;
            stall         <= 1'b1;
            flush_idx_reg <= '0;
            flush_wr_reg  <= 1'b0;
          end else if (rd || wr) begin
            req_addr_reg  <= addr[addr_width-1:0];
            req_wdata_reg <= wdata;
            req_wr_reg    <= wr;
            if (hit) begin
              if (wr) begin
                lines_reg[{in_index, hit_way}].data  <=
                  put_word(lines_reg[{in_index, hit_way}].data, in_off, wdata);
                lines_reg[{in_index, hit_way}].dirty <= 1'b1;
              end else begin
                rdata <= get_word(lines_reg[{in_index, hit_way}].data, in_off);
              end
            end else begin
              victim_way_reg <= victim_way;
              stall          <= 1'b1;
              if (lines_reg[{in_index, victim_way}].valid && lines_reg[{in_index, victim_way}].dirty) begin
                state_reg <= WB;
              end else begin
                state_reg <= REFILL;
              end
            end
          end
        end
        WB:     state_reg <= REFILL;
        REFILL: state_reg <= FILL;
        FILL: begin
          lines_reg[{req_index, victim_way_reg}].valid <= 1'b1;
          lines_reg[{req_index, victim_way_reg}].dirty <= req_wr_reg;
          lines_reg[{req_index, victim_way_reg}].tag   <= req_tag;
          if (req_wr_reg) begin
            lines_reg[{req_index, victim_way_reg}].data <= put_word(fill_data, req_off, req_wdata_reg);
          end else begin
            lines_reg[{req_index, victim_way_reg}].data <= fill_data;
            rdata <= get_word(fill_data, req_off);
          end
          stall     <= 1'b0;
          state_reg <= IDLE;
        end
        FLUSH: begin
          // A dirty line holds its slot for one extra cycle while the banks take it.
          if (lines_reg[flush_idx_reg].valid && lines_reg[flush_idx_reg].dirty && !flush_wr_reg) begin
            flush_wr_reg <= 1'b1;
          end else begin
            flush_wr_reg <= 1'b0;
            if (flush_idx_reg == loctn_bits'(num_lines - 1)) begin
              for (int i = 0; i < num_lines; i++) begin
                lines_reg[i].valid <= 1'b0;
                lines_reg[i].dirty <= 1'b0;
                age_reg[i]         <= '0;
              end
              stall     <= 1'b0;
              state_reg <= IDLE;
            end else begin
              flush_idx_reg <= flush_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (touch_en) begin
        for (int v = 0; v < num_ways; v++) begin
          age_reg[{touch_index, SET_OFFSET_BITS'(v)}] <= touched_age[v];
        end
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_top.sv
// Bench for set_assoc_cache_top: directed scenarios plus random traffic checked
// against a flat-memory / recency-timestamp reference model.
module tb_set_assoc_cache_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        flush;
  logic        rd;
  logic        wr;
  logic        stall;

  int checks = 0;
  int passes = 0;

  set_assoc_cache_top dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .flush (flush),
    .rd    (rd),
    .wr    (wr),
    .stall (stall)
  );

  always #5 clock = ~clock;

  // Reference model: processor-visible memory plus per-set way bookkeeping.
  logic [31:0] flat   [1024];
  bit          mv     [4][4];
  bit          md     [4][4];
  logic [5:0]  mt     [4][4];
  int          mts    [4][4];
  int          tick;
  logic [31:0] last_rd;

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int v = 0; v < 4; v++) begin
        mv[s][v] = 0; md[s][v] = 0; mts[s][v] = 0;
      end
    last_rd = 32'h0;
  endtask

  task automatic model_op(input logic r, w, f, input logic [31:0] a, d,
                          output int es, output logic [31:0] er);
    int set, way, ndirty;
    logic [5:0] tag;
    bit hit;
    es = 0;
    if (f) begin
      ndirty = 0;
      for (int s = 0; s < 4; s++)
        for (int v = 0; v < 4; v++) begin
          if (mv[s][v] && md[s][v]) ndirty++;
          mv[s][v] = 0; md[s][v] = 0;
        end
      es = 16 + ndirty;
    end else if (r || w) begin
      set = int'(a[3:2]);
      tag = a[9:4];
      hit = 0;
      way = -1;
      for (int v = 0; v < 4; v++)
        if (mv[set][v] && mt[set][v] == tag) begin hit = 1; way = v; end
      if (!hit) begin
        for (int v = 0; v < 4; v++)
          if (!mv[set][v] && way < 0) way = v;
        if (way < 0) begin
          way = 0;
          for (int v = 1; v < 4; v++)
            if (mts[set][v] < mts[set][way]) way = v;
        end
        es = (mv[set][way] && md[set][way]) ? 3 : 2;
        mv[set][way] = 1; md[set][way] = 0; mt[set][way] = tag;
      end
      tick++;
      mts[set][way] = tick;
      if (w) begin
        md[set][way] = 1;
        flat[a[9:0]] = d;
      end else begin
        last_rd = flat[a[9:0]];
      end
    end
    er = last_rd;
  endtask

  // Called and returns at posedge+1; pulses the request for exactly one edge.
  task automatic drive_op(input logic r, w, f, input logic [31:0] a, d,
                          output int ns, output logic [31:0] got);
    rd = r; wr = w; flush = f; addr = a; wdata = d;
    @(posedge clock); #1;
    rd = 0; wr = 0; flush = 0;
    ns = 0;
    while (stall === 1'b1 && ns < 200) begin
      ns++;
      @(posedge clock); #1;
    end
    got = rdata;
  endtask

  task automatic test_reset();
    checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passes++;
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else passes++;
    $display("reset: stall=%b rdata=%h", stall, rdata);
  endtask

  typedef struct {
    logic r; logic w; logic f; logic [31:0] a; logic [31:0] d; int es; logic [31:0] er;
  } dir_t;
  dir_t dir_tbl [14];

  task automatic test_directed();
    int ns, es;
    logic [31:0] got, er;
    dir_tbl = '{
      '{1'b1, 1'b0, 1'b0, 32'h010, 32'h0,        2,  32'h00000000},
      '{1'b0, 1'b1, 1'b0, 32'h000, 32'hDEADBEEF, 2,  32'h00000000},
      '{1'b1, 1'b0, 1'b0, 32'h000, 32'h0,        0,  32'hDEADBEEF},
      '{1'b0, 1'b1, 1'b0, 32'h004, 32'hBAADF00D, 2,  32'hDEADBEEF},
      '{1'b1, 1'b0, 1'b0, 32'h004, 32'h0,        0,  32'hBAADF00D},
      '{1'b1, 1'b0, 1'b0, 32'h000, 32'h0,        0,  32'hDEADBEEF},
      '{1'b0, 1'b0, 1'b1, 32'h000, 32'h0,        18, 32'hDEADBEEF},
      '{1'b1, 1'b0, 1'b0, 32'h000, 32'h0,        2,  32'hDEADBEEF},
      '{1'b0, 1'b1, 1'b0, 32'h000, 32'h11111111, 0,  32'hDEADBEEF},
      '{1'b1, 1'b0, 1'b0, 32'h010, 32'h0,        2,  32'h00000000},
      '{1'b1, 1'b0, 1'b0, 32'h020, 32'h0,        2,  32'h00000000},
      '{1'b1, 1'b0, 1'b0, 32'h030, 32'h0,        2,  32'h00000000},
      '{1'b1, 1'b0, 1'b0, 32'h040, 32'h0,        3,  32'h00000000},
      '{1'b1, 1'b0, 1'b0, 32'h000, 32'h0,        2,  32'h11111111}
    };
    for (int i = 0; i < 14; i++) begin
      drive_op(dir_tbl[i].r, dir_tbl[i].w, dir_tbl[i].f, dir_tbl[i].a, dir_tbl[i].d, ns, got);
      model_op(dir_tbl[i].r, dir_tbl[i].w, dir_tbl[i].f, dir_tbl[i].a, dir_tbl[i].d, es, er);
      $display("directed %0d: rd=%b wr=%b fl=%b addr=%h stall_cycles=%0d rdata=%h",
               i, dir_tbl[i].r, dir_tbl[i].w, dir_tbl[i].f, dir_tbl[i].a, ns, got);
      checks++;
      if (ns !== dir_tbl[i].es)
        $display("FAIL directed_stall step %0d: got %0d want %0d", i, ns, dir_tbl[i].es);
      else passes++;
      checks++;
      if (got !== dir_tbl[i].er)
        $display("FAIL directed_rdata step %0d: got %h want %h", i, got, dir_tbl[i].er);
      else passes++;
    end
  endtask

  task automatic test_stall_ignore();
    int ns, es;
    logic [31:0] got, er;
    logic [31:0] a1, a2;
    drive_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ns, got);
    model_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, es, er);
    checks++;
    if (ns !== es) $display("FAIL ignore_flush_stall: got %0d want %0d", ns, es); else passes++;
    a1 = 32'h0000_0123;
    a2 = 32'h0000_0237;
    rd = 1; addr = a1;
    @(posedge clock); #1;
    rd = 0;
    ns = 0;
    while (stall === 1'b1 && ns < 200) begin
      if (ns == 0) begin rd = 1; wr = 1; addr = a2; wdata = $urandom; end
      ns++;
      @(posedge clock); #1;
      rd = 0; wr = 0;
    end
    model_op(1'b1, 1'b0, 1'b0, a1, 32'h0, es, er);
    $display("ignore: addr=%h stall_cycles=%0d rdata=%h", a1, ns, rdata);
    checks++;
    if (ns !== es) $display("FAIL ignore_stall: got %0d want %0d", ns, es); else passes++;
    checks++;
    if (rdata !== er) $display("FAIL ignore_rdata: got %h want %h", rdata, er); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b0) $display("FAIL ignore_no_phantom cycle %0d: got %b want 0", i, stall); else passes++;
      @(posedge clock); #1;
    end
    drive_op(1'b1, 1'b0, 1'b0, a2, 32'h0, ns, got);
    model_op(1'b1, 1'b0, 1'b0, a2, 32'h0, es, er);
    $display("ignore: readback addr=%h stall_cycles=%0d rdata=%h", a2, ns, got);
    checks++;
    if (got !== er) $display("FAIL ignore_write_dropped: got %h want %h", got, er); else passes++;
  endtask

  task automatic test_reset_mid_refill();
    int ns, es;
    logic [31:0] got, er;
    logic [31:0] a;
    drive_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ns, got);
    model_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, es, er);
    checks++;
    if (ns !== es) $display("FAIL midreset_flush_stall: got %0d want %0d", ns, es); else passes++;
    a = 32'h0000_0004;
    rd = 1; addr = a;
    @(posedge clock); #1;
    rd = 0;
    checks++;
    if (stall !== 1'b1) $display("FAIL midreset_stall_before: got %b want 1", stall); else passes++;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    $display("midreset: stall=%b rdata=%h", stall, rdata);
    checks++;
    if (stall !== 1'b0) $display("FAIL midreset_stall_after: got %b want 0", stall); else passes++;
    checks++;
    if (rdata !== 32'h0) $display("FAIL midreset_rdata: got %h want 00000000", rdata); else passes++;
    drive_op(1'b1, 1'b0, 1'b0, a, 32'h0, ns, got);
    model_op(1'b1, 1'b0, 1'b0, a, 32'h0, es, er);
    $display("midreset: readback addr=%h stall_cycles=%0d rdata=%h", a, ns, got);
    checks++;
    if (ns !== es) $display("FAIL midreset_read_stall: got %0d want %0d", ns, es); else passes++;
    checks++;
    if (got !== er) $display("FAIL midreset_read_rdata: got %h want %h", got, er); else passes++;
  endtask

  task automatic test_random();
    int ns, es, p;
    logic [31:0] got, er, a, d;
    logic r, w, f;
    for (int i = 0; i < 250; i++) begin
      p = $urandom_range(0, 99);
      f = (p < 3);
      w = (p >= 50);
      r = (p < 1) || (p >= 3 && p < 50) || (p >= 90);
      a = $urandom;
      a[9:0] = {6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d = $urandom;
      drive_op(r, w, f, a, d, ns, got);
      model_op(r, w, f, a, d, es, er);
      $display("random %0d: rd=%b wr=%b fl=%b addr=%h wdata=%h stall_cycles=%0d rdata=%h",
               i, r, w, f, a, d, ns, got);
      checks++;
      if (ns !== es) $display("FAIL random_stall op %0d: got %0d want %0d", i, ns, es); else passes++;
      checks++;
      if (got !== er) $display("FAIL random_rdata op %0d: got %h want %h", i, got, er); else passes++;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    reset = 1; rd = 0; wr = 0; flush = 0; addr = '0; wdata = '0;
    for (int i = 0; i < 1024; i++) flat[i] = 32'h0;
    tick = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    test_reset();
    test_directed();
    test_stall_ignore();
    test_reset_mid_refill();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
